pca_mmio_regbank: RTL and testbench

AXI4-Lite slave register bank that sits directly downstream of the PCA AXI MMIO bridge and terminates its MMIO traffic. Provides an ID register, a scratch register, a control register that drives PL logic, a gated free-running cycle counter, and a small interrupt block (status/enable with write-1-to-clear). Write and read channels are independent, fully registered, and honour master backpressure.

---
 rtl/pca_mmio_regbank_if.sv | 36 +++
 rtl/pca_mmio_regbank.sv | 155 +++++++++++++++
 tb/tb_pca_mmio_regbank.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pca_mmio_regbank_if.sv
// rtl/pca_mmio_regbank_if.sv - AXI4-Lite link between the PCA MMIO bridge and the register bank
// Ports: AW (awaddr/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//        B (bresp/bvalid/bready), AR (araddr/arvalid/arready), R (rdata/rresp/rvalid/rready).
interface pca_mmio_regbank_if;
  logic [31:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [31:0] s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/pca_mmio_regbank.sv
// rtl/pca_mmio_regbank.sv - AXI4-Lite register bank: ID, scratch, control, cycle counter, interrupts
// Ports: s_axi_aclk (clock), s_axi_areset (sync, active-high), axi (AXI4-Lite slave),
//        irq_event (event pulses), ctrl_out (CTRL[7:0]), irq (registered level interrupt).
module pca_mmio_regbank #(
  parameter logic [31:0] ID_VALUE    = 32'h0CA0_0001,
  parameter int          NUM_IRQ     = 4,
  parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
  input  logic               s_axi_aclk,
  input  logic               s_axi_areset,
  pca_mmio_regbank_if.slave  axi,
  input  logic [NUM_IRQ-1:0] irq_event,
  output logic [7:0]         ctrl_out,
  output logic               irq
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic               aw_held, w_held;
  logic [5:0]         aw_addr_q;
  logic [31:0]        w_data_q;
  logic [3:0]         w_strb_q;
  logic               bvalid_q, rvalid_q;
  logic [1:0]         bresp_q, rresp_q;
  logic [31:0]        rdata_q;
  logic [31:0]        scratch_q, count_q;
  logic [7:0]         ctrl_q;
  logic [NUM_IRQ-1:0] irq_status_q, irq_enable_q;
  logic               irq_q;

  logic               aw_fire, w_fire, ar_fire, commit, wr_ok;
  logic               we_scratch, we_ctrl, we_status, we_enable, count_clr;
  logic [31:0]        wr_mask, count_next, rd_data;
  logic               rd_ok;
  logic [NUM_IRQ-1:0] irq_w1c, irq_status_next;
  logic               unused_addr_bits;

  assign axi.s_axi_awready = !aw_held && !bvalid_q;
  assign axi.s_axi_wready  = !w_held && !bvalid_q;
  assign axi.s_axi_arready = !rvalid_q;
  assign axi.s_axi_bvalid  = bvalid_q;
  assign axi.s_axi_bresp   = bresp_q;
  assign axi.s_axi_rvalid  = rvalid_q;
  assign axi.s_axi_rresp   = rresp_q;
  assign axi.s_axi_rdata   = rdata_q;
  assign ctrl_out          = ctrl_q;
  assign irq               = irq_q;

  // The bridge has already decoded the base address; only the word offset matters here.
  assign unused_addr_bits = ^{axi.s_axi_awaddr[31:8], axi.s_axi_awaddr[1:0],
                              axi.s_axi_araddr[31:8], axi.s_axi_araddr[1:0]};

  assign aw_fire = axi.s_axi_awvalid && axi.s_axi_awready;
  assign w_fire  = axi.s_axi_wvalid && axi.s_axi_wready;
  assign ar_fire = axi.s_axi_arvalid && axi.s_axi_arready;
  assign commit  = aw_held && w_held && !bvalid_q;

  assign wr_mask    = {{8{w_strb_q[3]}}, {8{w_strb_q[2]}}, {8{w_strb_q[1]}}, {8{w_strb_q[0]}}};
  assign wr_ok      = (aw_addr_q <= 6'h05);
  assign we_scratch = commit && (aw_addr_q == 6'h01);
  assign we_ctrl    = commit && (aw_addr_q == 6'h02) && w_strb_q[0];
  assign we_status  = commit && (aw_addr_q == 6'h04);
  assign we_enable  = commit && (aw_addr_q == 6'h05);

  // Clear beats increment; it acts on the commit edge straight from the write data.
  assign count_clr  = we_ctrl && w_data_q[1];
  assign count_next = count_clr  ? 32'd0 :
                      ctrl_q[0]  ? count_q + 32'd1 : count_q;

  // A new event wins over a W1C of the same bit because the OR is applied last.
  assign irq_w1c         = we_status ? (w_data_q[NUM_IRQ-1:0] & wr_mask[NUM_IRQ-1:0]) : '0;
  assign irq_status_next = (irq_status_q & ~irq_w1c) | irq_event;

  always_comb begin
    rd_data = '0;
    rd_ok   = 1'b1;
    case (axi.s_axi_araddr[7:2])
      6'h00: rd_data = ID_VALUE;
      6'h01: rd_data = scratch_q;
      6'h02: rd_data[7:0] = ctrl_q & 8'hFD;  // bit1 is a strobe and never reads back
      6'h03: rd_data = count_q;
      6'h04: rd_data[NUM_IRQ-1:0] = irq_status_q;
      6'h05: rd_data[NUM_IRQ-1:0] = irq_enable_q;
      default: rd_ok = 1'b0;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      rvalid_q     <= 1'b0;
      rresp_q      <= RESP_OKAY;
      rdata_q      <= '0;
      scratch_q    <= SCRATCH_RST;
      ctrl_q       <= '0;
      count_q      <= '0;
      irq_status_q <= '0;
      irq_enable_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      if (aw_fire) begin
        aw_held   <= 1'b1;
        aw_addr_q <= axi.s_axi_awaddr[7:2];
      end
      if (w_fire) begin
        w_held   <= 1'b1;
        w_data_q <= axi.s_axi_wdata;
        w_strb_q <= axi.s_axi_wstrb;
      end

      // aw_fire/w_fire cannot coincide with commit: the holds block their readies.
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && axi.s_axi_bready) begin
        bvalid_q <= 1'b0;
      end

      if (we_scratch)
        scratch_q <= (scratch_q & ~wr_mask) | (w_data_q & wr_mask);

      if (we_ctrl)
        ctrl_q <= w_data_q[7:0];
      else
        ctrl_q[1] <= 1'b0;

      if (we_enable)
        irq_enable_q <= (irq_enable_q & ~wr_mask[NUM_IRQ-1:0]) |
                        (w_data_q[NUM_IRQ-1:0] & wr_mask[NUM_IRQ-1:0]);

      count_q      <= count_next;
      irq_status_q <= irq_status_next;
      irq_q        <= |(irq_status_q & irq_enable_q);

      // Read mux sees pre-write register values, so same-edge writes are not visible yet.
      if (ar_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q && axi.s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pca_mmio_regbank.sv
// tb/tb_pca_mmio_regbank.sv - scoreboard bench for the pca_mmio_regbank AXI4-Lite register bank
module tb_pca_mmio_regbank;
  localparam int          NUM_IRQ = 4;
  localparam logic [31:0] ID_VAL  = 32'h0CA0_0001;

  logic               clk = 1'b0;
  logic               areset;
  logic [NUM_IRQ-1:0] irq_event;
  logic [7:0]         ctrl_out;
  logic               irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];

  pca_mmio_regbank_if axi_if ();

  pca_mmio_regbank #(
    .ID_VALUE(ID_VAL),
    .NUM_IRQ(NUM_IRQ),
    .SCRATCH_RST(32'h0000_0000)
  ) dut (
    .s_axi_aclk(clk),
    .s_axi_areset(areset),
    .axi(axi_if),
    .irq_event(irq_event),
    .ctrl_out(ctrl_out),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp,
                           input logic [NUM_IRQ-1:0] ev);
    int lat;
    logic got;
    @(negedge clk);
    axi_if.s_axi_awaddr  = addr;
    axi_if.s_axi_awvalid = 1'b1;
    axi_if.s_axi_wdata   = data;
    axi_if.s_axi_wstrb   = strb;
    axi_if.s_axi_wvalid  = 1'b1;
    exp_b.push_back(resp);
    @(posedge clk);
    @(negedge clk);
    axi_if.s_axi_awvalid = 1'b0;
    axi_if.s_axi_wvalid  = 1'b0;
    axi_if.s_axi_bready  = 1'b1;
    irq_event = ev;                 // lands on the commit edge
    @(posedge clk);
    @(negedge clk);
    irq_event = '0;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (axi_if.s_axi_bvalid) begin
        got = 1'b1;
        check_eq({tag, "_bresp"}, {30'd0, axi_if.s_axi_bresp}, {30'd0, exp_b.pop_front()});
        check_eq({tag, "_blat"}, lat, 0);
        @(posedge clk);
      end else begin
        lat++;
        @(posedge clk);
        @(negedge clk);
      end
    end
    check_eq({tag, "_bseen"}, {31'd0, got}, 32'd1);
    #1 axi_if.s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int lat;
    logic got;
    logic [33:0] e;
    @(negedge clk);
    axi_if.s_axi_araddr  = addr;
    axi_if.s_axi_arvalid = 1'b1;
    exp_r.push_back({exp_resp, exp_data});
    @(posedge clk);
    @(negedge clk);
    axi_if.s_axi_arvalid = 1'b0;
    axi_if.s_axi_rready  = 1'b1;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (axi_if.s_axi_rvalid) begin
        got = 1'b1;
        e = exp_r.pop_front();
        check_eq({tag, "_rdata"}, axi_if.s_axi_rdata, e[31:0]);
        check_eq({tag, "_rresp"}, {30'd0, axi_if.s_axi_rresp}, {30'd0, e[33:32]});
        check_eq({tag, "_rlat"}, lat, 0);
        @(posedge clk);
      end else begin
        lat++;
        @(posedge clk);
        @(negedge clk);
      end
    end
    check_eq({tag, "_rseen"}, {31'd0, got}, 32'd1);
    #1 axi_if.s_axi_rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic any_b;
    areset = 1'b1;
    irq_event = '0;
    axi_if.s_axi_awaddr = '0;  axi_if.s_axi_awvalid = 1'b0;
    axi_if.s_axi_wdata  = '0;  axi_if.s_axi_wstrb   = '0;  axi_if.s_axi_wvalid = 1'b0;
    axi_if.s_axi_bready = 1'b0;
    axi_if.s_axi_araddr = '0;  axi_if.s_axi_arvalid = 1'b0;
    axi_if.s_axi_rready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    areset = 1'b0;

    // Reset state
    check_eq("rst_ready", {29'd0, axi_if.s_axi_awready, axi_if.s_axi_wready, axi_if.s_axi_arready}, 32'd7);
    check_eq("rst_valid", {30'd0, axi_if.s_axi_bvalid, axi_if.s_axi_rvalid}, 32'd0);
    check_eq("rst_rdata", axi_if.s_axi_rdata, 32'd0);
    check_eq("rst_out", {23'd0, ctrl_out, irq}, 32'd0);

    axi_read("id", 32'h00, ID_VAL, 2'b00);
    axi_read("scr_rst", 32'h04, 32'h0, 2'b00);
    axi_read("id_hi", 32'hFFFF_FF00, ID_VAL, 2'b00);

    // Byte strobes on SCRATCH
    axi_write("scr_full", 32'h04, 32'h1122_3344, 4'hF, 2'b00, '0);
    axi_write("scr_strb", 32'h04, 32'hA5A5_A5A5, 4'h5, 2'b00, '0);
    axi_read("scr_strb", 32'h04, 32'h11A5_33A5, 2'b00);

    // W three cycles ahead of AW, response held off by bready for four cycles
    @(negedge clk);
    axi_if.s_axi_wdata  = 32'hDEAD_BEEF;
    axi_if.s_axi_wstrb  = 4'hF;
    axi_if.s_axi_wvalid = 1'b1;
    exp_b.push_back(2'b00);
    @(posedge clk);
    @(negedge clk);
    axi_if.s_axi_wvalid = 1'b0;
    check_eq("w_held_ready", {31'd0, axi_if.s_axi_wready}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    axi_if.s_axi_awaddr  = 32'h04;
    axi_if.s_axi_awvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    axi_if.s_axi_awvalid = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("b_hold", {27'd0, axi_if.s_axi_bvalid, axi_if.s_axi_awready, axi_if.s_axi_wready,
                          axi_if.s_axi_bresp}, {27'd0, 3'b100, exp_b[0]});
      if (i < 3) @(posedge clk);
    end
    void'(exp_b.pop_front());
    axi_if.s_axi_bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    axi_if.s_axi_bready = 1'b0;
    any_b = axi_if.s_axi_bvalid;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      any_b = any_b | axi_if.s_axi_bvalid;
    end
    check_eq("b_once", {31'd0, any_b}, 32'd0);
    axi_read("w_first", 32'h04, 32'hDEAD_BEEF, 2'b00);

    // Read-only register ignores writes
    axi_write("id_wr", 32'h00, 32'h1234_5678, 4'hF, 2'b00, '0);
    axi_read("id_after", 32'h00, ID_VAL, 2'b00);

    // Counter: enabled at commit edge C, increments on C+1..C+11, sampled at AR edge C+12
    axi_write("ctrl_en", 32'h08, 32'h1, 4'h1, 2'b00, '0);
    repeat (10) @(posedge clk);
    axi_read("count_run", 32'h0C, 32'd11, 2'b00);
    // Clear zeroes on commit C', one increment on C'+1, read sampled at C'+2
    axi_write("ctrl_clr", 32'h08, 32'h3, 4'h1, 2'b00, '0);
    axi_read("count_clr", 32'h0C, 32'd1, 2'b00);
    axi_read("ctrl_rd", 32'h08, 32'h1, 2'b00);
    check_eq("ctrl_out", {24'd0, ctrl_out}, 32'h1);

    // Wrap: park the stopped counter at all-ones, then enable it
    axi_write("ctrl_stop", 32'h08, 32'h0, 4'h1, 2'b00, '0);
    @(negedge clk);
    force dut.count_q = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.count_q;
    axi_read("count_max", 32'h0C, 32'hFFFF_FFFF, 2'b00);
    axi_write("ctrl_wrap", 32'h08, 32'h1, 4'h1, 2'b00, '0);
    axi_read("count_wrap", 32'h0C, 32'd0, 2'b00);

    // Interrupts
    axi_write("irq_en", 32'h14, 32'h4, 4'hF, 2'b00, '0);
    @(negedge clk);
    irq_event = 4'h4;
    @(posedge clk);
    @(negedge clk);
    irq_event = '0;
    check_eq("irq_lag", {31'd0, irq}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq("irq_set", {31'd0, irq}, 32'd1);
    axi_read("irq_stat", 32'h10, 32'h4, 2'b00);
    axi_write("w1c_race", 32'h10, 32'h4, 4'hF, 2'b00, 4'h4);
    axi_read("irq_race", 32'h10, 32'h4, 2'b00);
    check_eq("irq_race_lvl", {31'd0, irq}, 32'd1);
    axi_write("w1c", 32'h10, 32'h4, 4'hF, 2'b00, '0);
    @(negedge clk);
    check_eq("irq_clr", {31'd0, irq}, 32'd0);
    axi_read("irq_stat0", 32'h10, 32'h0, 2'b00);

    // Unmapped offsets
    axi_read("unmap", 32'h40, 32'h0, 2'b10);
    axi_write("unmap_wr", 32'h40, 32'hFFFF_FFFF, 4'hF, 2'b10, '0);
    axi_read("scr_keep", 32'h04, 32'hDEAD_BEEF, 2'b00);
    axi_read("en_keep", 32'h14, 32'h4, 2'b00);

    // Reset while a write response is pending
    @(negedge clk);
    irq_event = 4'h4;
    @(posedge clk);
    @(negedge clk);
    irq_event = '0;
    axi_if.s_axi_awaddr  = 32'h04;
    axi_if.s_axi_wdata   = 32'h0000_0055;
    axi_if.s_axi_wstrb   = 4'hF;
    axi_if.s_axi_awvalid = 1'b1;
    axi_if.s_axi_wvalid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    axi_if.s_axi_awvalid = 1'b0;
    axi_if.s_axi_wvalid  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("pre_rst", {30'd0, axi_if.s_axi_bvalid, irq}, 32'd3);
    areset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    areset = 1'b0;
    check_eq("rst2_valid", {30'd0, axi_if.s_axi_bvalid, axi_if.s_axi_rvalid}, 32'd0);
    check_eq("rst2_ready", {29'd0, axi_if.s_axi_awready, axi_if.s_axi_wready, axi_if.s_axi_arready}, 32'd7);
    check_eq("rst2_out", {23'd0, ctrl_out, irq}, 32'd0);
    any_b = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      any_b = any_b | axi_if.s_axi_bvalid;
    end
    check_eq("rst2_nob", {31'd0, any_b}, 32'd0);
    axi_read("rst2_scr", 32'h04, 32'h0, 2'b00);
    axi_read("rst2_ctrl", 32'h08, 32'h0, 2'b00);
    axi_read("rst2_cnt", 32'h0C, 32'h0, 2'b00);
    axi_read("rst2_stat", 32'h10, 32'h0, 2'b00);
    axi_read("rst2_en", 32'h14, 32'h0, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
